// File: rtl/key_lock_ctrl.sv
// key_lock_ctrl: serial unlock-key receiver/comparator that gates the core's key bus.
// Optional feature macro AUTO_RELOCK_EN: relock after RELOCK_CYCLES idle cycles while unlocked.
module key_lock_ctrl #(
    parameter int unsigned      KEY_W         = 64,
    parameter int unsigned      BEAT_W        = 8,
    parameter logic [KEY_W-1:0] GOLDEN_KEY    = 64'hA5C3_0F1E_5A3C_F0E1,
    parameter int unsigned      MAX_FAIL      = 3,
    parameter int unsigned      RELOCK_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BEAT_W-1:0] key_in,
    input  logic              key_valid,
    input  logic              key_last,
    output logic              key_ready,
    input  logic              lock_req,
    input  logic              core_active,
    output logic [KEY_W-1:0]  key_out,
    output logic              unlocked,
    output logic              lockout,
    output logic [3:0]        fail_cnt
);

    localparam int unsigned       BEATS     = KEY_W / BEAT_W;
    localparam int unsigned       BCNT_W    = $clog2(BEATS + 1);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS);
    localparam logic [3:0]        FAIL_MAX  = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_LOCKED,
        S_LOAD,
        S_CHECK,
        S_UNLOCKED,
        S_LOCKOUT
    } state_t;

    state_t              state;
    logic [KEY_W-1:0]    sr;
    logic [BCNT_W-1:0]   beat_cnt;
    logic                bad;

    logic                accept;
    logic [BCNT_W-1:0]   beat_nxt;
    logic                final_beat;
    logic                beat_bad;
    logic [KEY_W-1:0]    sr_nxt;
    logic [3:0]          fail_inc;
    logic                relock;

    // Per-beat decode shared by LOCKED (first beat) and LOAD.
    assign accept     = key_valid && key_ready;
    assign beat_nxt   = beat_cnt + BCNT_W'(1);
    assign final_beat = (beat_nxt == LAST_BEAT);
    assign beat_bad   = final_beat ? !key_last : key_last;
    assign sr_nxt     = KEY_W'({sr, key_in});
    assign fail_inc   = (fail_cnt >= FAIL_MAX) ? fail_cnt : fail_cnt + 4'd1;

`ifdef AUTO_RELOCK_EN
    localparam int unsigned     RC_W   = $clog2(RELOCK_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(RELOCK_CYCLES);

    logic [RC_W-1:0] idle_cnt;

    // Idle counter: held at zero outside UNLOCKED and whenever the core is busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (state != S_UNLOCKED || core_active) begin
            idle_cnt <= '0;
        end else if (idle_cnt != RC_MAX) begin
            idle_cnt <= idle_cnt + RC_W'(1);
        end
    end

    assign relock = lock_req || (idle_cnt == RC_MAX);
`else
    logic unused_core_active;

    assign unused_core_active = core_active;
    assign relock             = lock_req;
`endif

    // Controller FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_LOCKED;
            sr        <= '0;
            beat_cnt  <= '0;
            bad       <= 1'b0;
            key_ready <= 1'b0;
            key_out   <= '0;
            unlocked  <= 1'b0;
            lockout   <= 1'b0;
            fail_cnt  <= '0;
        end else begin
            case (state)
                S_LOCKED, S_LOAD: begin
                    if (state == S_LOAD && lock_req) begin
                        // Abort wins over a coinciding beat.
                        state     <= S_LOCKED;
                        sr        <= '0;
                        beat_cnt  <= '0;
                        bad       <= 1'b0;
                        key_ready <= 1'b1;
                    end else if (accept) begin
                        sr       <= sr_nxt;
                        beat_cnt <= beat_nxt;
                        bad      <= bad | beat_bad;
                        if (final_beat || key_last) begin
                            state     <= S_CHECK;
                            key_ready <= 1'b0;
                        end else begin
                            state     <= S_LOAD;
                            key_ready <= 1'b1;
                        end
                    end else begin
                        key_ready <= 1'b1;
                    end
                end

                S_CHECK: begin
                    sr       <= '0;
                    beat_cnt <= '0;
                    bad      <= 1'b0;
                    if (sr == GOLDEN_KEY && !bad) begin
                        state     <= S_UNLOCKED;
                        fail_cnt  <= '0;
                        key_ready <= 1'b0;
                    end else begin
                        fail_cnt <= fail_inc;
                        if (fail_inc == FAIL_MAX) begin
                            state     <= S_LOCKOUT;
                            lockout   <= 1'b1;
                            key_ready <= 1'b0;
                        end else begin
                            state     <= S_LOCKED;
                            key_ready <= 1'b1;
                        end
                    end
                end

                S_UNLOCKED: begin
                    if (relock) begin
                        state     <= S_LOCKED;
                        key_out   <= '0;
                        unlocked  <= 1'b0;
                        key_ready <= 1'b1;
                    end else begin
                        key_out   <= GOLDEN_KEY;
                        unlocked  <= 1'b1;
                        key_ready <= 1'b0;
                    end
                end

                S_LOCKOUT: begin
                    key_ready <= 1'b0;
                    key_out   <= '0;
                    lockout   <= 1'b1;
                end

                default: begin
                    state     <= S_LOCKED;
                    key_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_lock_ctrl.sv
// Scoreboard bench for key_lock_ctrl: attempt-level reference model feeds an expected-change queue.
module tb_key_lock_ctrl;

    localparam int          N    = 8;
    localparam logic [63:0] GOLD = 64'hA5C3_0F1E_5A3C_F0E1;
    localparam logic [3:0]  MAXF = 4'd3;

    logic        clk, rst, key_valid, key_last, key_ready, lock_req, core_active;
    logic        unlocked, lockout;
    logic [7:0]  key_in;
    logic [63:0] key_out;
    logic [3:0]  fail_cnt;

    typedef struct {
        logic        unl;
        logic        lo;
        logic [3:0]  fc;
        logic        rdy;
        logic [63:0] ko;
        int          at;
    } snap_t;

    snap_t exp_q[$];
    int    vectors = 0;
    int    fails   = 0;
    int    cyc     = 0;
    int    m_fail;
    bit    m_unl, m_lo;

    key_lock_ctrl #(.RELOCK_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
        .key_last(key_last), .key_ready(key_ready), .lock_req(lock_req),
        .core_active(core_active), .key_out(key_out), .unlocked(unlocked),
        .lockout(lockout), .fail_cnt(fail_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    // Monitor: every visible status change must match the next queued expectation.
    logic [5:0] prev = '0;
    always @(negedge clk) begin
        snap_t      e;
        logic [5:0] cur;
        cur = {unlocked, lockout, fail_cnt};
        if (cur !== prev) begin
            vectors++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change cyc=%0d got unl=%b lo=%b fc=%0d, wanted no change",
                         cyc, unlocked, lockout, fail_cnt);
            end else begin
                e = exp_q.pop_front();
                if (unlocked !== e.unl || lockout !== e.lo || fail_cnt !== e.fc ||
                    key_ready !== e.rdy || key_out !== e.ko || (e.at >= 0 && cyc != e.at)) begin
                    fails++;
                    $display("FAIL status cyc=%0d got unl=%b lo=%b fc=%0d rdy=%b ko=%h want unl=%b lo=%b fc=%0d rdy=%b ko=%h cyc=%0d",
                             cyc, unlocked, lockout, fail_cnt, key_ready, key_out,
                             e.unl, e.lo, e.fc, e.rdy, e.ko, e.at);
                end
            end
        end
        prev = cur;
    end

    function automatic void push(input logic unl, input logic lo, input logic [3:0] fc,
                                 input logic rdy, input logic [63:0] ko, input int at);
        snap_t s;
        s = '{unl, lo, fc, rdy, ko, at};
        exp_q.push_back(s);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One beat; acc_cyc returns the edge number that accepts it.
    task automatic send_beat(input logic [7:0] b, input bit last, input bit abort, output int acc_cyc);
        int n;
        n = 0;
        key_in = b; key_valid = 1'b1; key_last = last; lock_req = abort;
        while (!key_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!key_ready) begin
            fails++;
            $display("FAIL handshake key_ready=%b want 1 within 20 cycles", key_ready);
        end
        acc_cyc = cyc + 1;
        @(negedge clk);
        key_valid = 1'b0; key_last = 1'b0; lock_req = 1'b0;
    endtask

    // last_at: beat index carrying key_last (0 = never); abort_at: beat paired with lock_req (0 = none).
    task automatic attempt(input logic [63:0] key, input int last_at, input int abort_at, output int e);
        int  term;
        bit  match;
        term = N;
        e    = 0;
        for (int i = 1; i <= N; i++) begin
            if (abort_at == i) begin
                send_beat(key[64-8*i +: 8], i == last_at, 1'b1, e);
                idle(1);
                return;
            end
            send_beat(key[64-8*i +: 8], i == last_at, 1'b0, e);
            if (i == last_at || i == N) begin
                term = i;
                break;
            end
            idle($urandom_range(0, 2));
        end
        match = (term == N) && (last_at == N) && (key == GOLD);
        if (match) begin
            if (m_fail != 0) push(1'b0, 1'b0, 4'd0, 1'b0, 64'd0, e + 1);
            push(1'b1, 1'b0, 4'd0, 1'b0, GOLD, e + 2);
            m_fail = 0;
            m_unl  = 1'b1;
        end else begin
            if (m_fail < int'(MAXF)) m_fail++;
            m_lo = (m_fail == int'(MAXF));
            push(1'b0, m_lo, 4'(m_fail), !m_lo, 64'd0, e + 1);
        end
        idle(3);
    endtask

    task automatic relock();
        int e;
        lock_req = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        lock_req = 1'b0;
        if (m_unl) begin
            push(1'b0, 1'b0, 4'(m_fail), 1'b1, 64'd0, e);
            m_unl = 1'b0;
        end
    endtask

    // Offer a full correct key while the controller must refuse it.
    task automatic poke_ignored();
        logic [63:0] k;
        k = GOLD;
        for (int i = 1; i <= N; i++) begin
            key_in = k[64-8*i +: 8]; key_valid = 1'b1; key_last = (i == N);
            lock_req = m_lo && (i == 3);
            @(negedge clk);
            check("ready_low_ignored", 64'(key_ready), 64'd0);
        end
        key_valid = 1'b0; key_last = 1'b0; lock_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_reset_status", 64'({unlocked, lockout, fail_cnt, key_ready}), 64'd0);
        check("async_reset_key_out", key_out, 64'd0);
        if (m_unl || m_lo || m_fail != 0) push(1'b0, 1'b0, 4'd0, 1'b0, 64'd0, -1);
        m_unl = 1'b0; m_lo = 1'b0; m_fail = 0;
        idle(2);
        rst = 1'b1;
        idle(1);
        check("ready_after_reset", 64'(key_ready), 64'd1);
    endtask

    initial begin
        int    e;
        int    r;
        snap_t s;
        rst = 1'b1; key_in = '0; key_valid = 1'b0; key_last = 1'b0;
        lock_req = 1'b0; core_active = 1'b1;
        m_fail = 0; m_unl = 1'b0; m_lo = 1'b0;
        #1 rst = 1'b0;
        #2;
        check("reset_status", 64'({unlocked, lockout, fail_cnt, key_ready}), 64'd0);
        check("reset_key_out", key_out, 64'd0);
        idle(2);
        rst = 1'b1;
        idle(1);
        check("ready_after_reset", 64'(key_ready), 64'd1);

        // Directed scenarios.
        attempt(GOLD, N, 0, e);
        poke_ignored();
        relock();
        attempt(GOLD, N, 5, e);
        check("fail_after_abort", 64'(fail_cnt), 64'd0);
        attempt(GOLD, N, 0, e);
        relock();
        attempt(GOLD, 4, 0, e);
        check("unlocked_after_early_last", 64'(unlocked), 64'd0);
        attempt(GOLD, N, 0, e);
        relock();
        repeat (3) attempt(GOLD ^ 64'd1, N, 0, e);
        poke_ignored();
        do_reset();
        attempt(GOLD, N, 0, e);
        idle(2);
        do_reset();

`ifdef AUTO_RELOCK_EN
        core_active = 1'b0;
        attempt(GOLD, N, 0, e);
        push(1'b0, 1'b0, 4'd0, 1'b1, 64'd0, e + 1 + 17);
        m_unl = 1'b0;
        idle(20);
        attempt(GOLD, N, 0, e);
        while (cyc < e + 10) @(negedge clk);
        core_active = 1'b1;
        @(negedge clk);
        core_active = 1'b0;
        push(1'b0, 1'b0, 4'd0, 1'b1, 64'd0, e + 1 + 27);
        m_unl = 1'b0;
        idle(30);
        core_active = 1'b1;
`endif

        // Randomized attempts.
        for (int it = 0; it < 60; it++) begin
            if (m_lo) begin
                poke_ignored();
                do_reset();
            end else if (m_unl) begin
                idle($urandom_range(0, 4));
                if ($urandom_range(0, 3) == 0) do_reset();
                else relock();
            end else begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1, 2, 3: attempt(GOLD, N, 0, e);
                    4:          attempt(GOLD ^ (64'd1 << $urandom_range(0, 63)), N, 0, e);
                    5:          attempt({$urandom, $urandom}, N, 0, e);
                    6:          attempt(GOLD, $urandom_range(1, N - 1), 0, e);
                    7:          attempt(GOLD, 0, 0, e);
                    8:          attempt(GOLD, N, $urandom_range(2, N), e);
                    default: begin
                        lock_req = 1'b1;
                        @(negedge clk);
                        lock_req = 1'b0;
                    end
                endcase
            end
        end

        idle(5);
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            vectors++;
            fails++;
            $display("FAIL missing_change want unl=%b lo=%b fc=%0d at cyc=%0d, never observed",
                     s.unl, s.lo, s.fc, s.at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
